mem_scan_feeder: RTL and testbench

Sequential producer for the debug display's MEM_Addr/MEM_Data snoop port. It continuously sweeps a window of ROM or RAM words through a req/ack memory read port. Each word read is presented as a stable relative-address/data pair for a programmable hold time, so the display's capture buffer fills without CPU involvement. It sits between the SOC memory read mux and the VGA debug block; sel is the same switch (SWO13) the display uses to pick its ROM/RAM buffer half.

---
 rtl/mem_scan_feeder.sv | 176 +++++++++++++++++
 tb/tb_mem_scan_feeder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_scan_feeder.sv
// mem_scan_feeder
//   Sweeps a window of ROM or RAM words through a req/ack read port and
//   presents each word as a stable {relative address, data} pair on the
//   debug display's MEM_Addr/MEM_Data snoop port for a programmable hold.
//
// Ports:
//   clk, rst          clock / asynchronous active-high reset
//   en                sweep enable (level)
//   sel               0 = ROM window, 1 = RAM window
//   mem_req/mem_addr  read request (held until ack or timeout), byte address
//   mem_ack/mem_rdata read complete, data valid in the ack cycle
//   MEM_Addr/MEM_Data presented relative byte address / data
//   upd               one-cycle pulse when the presented pair changes
//   sweep_done        one-cycle pulse after the last word of a window
module mem_scan_feeder #(
    parameter int          WORDS    = 128,
    parameter logic [31:0] ROM_BASE = 32'h0000_0000,
    parameter logic [31:0] RAM_BASE = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          HOLD_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        sel,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] MEM_Addr,
    output logic [31:0] MEM_Data,
    output logic        upd,
    output logic        sweep_done
);

    localparam int IW = $clog2(WORDS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);

    localparam logic [IW-1:0] IDX_LAST  = IW'(WORDS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC);
    localparam logic [31:0]   DEAD_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, ISSUE, PRESENT, HOLD} state_t;

    state_t        state, state_d;
    logic [IW-1:0] idx, idx_d;
    logic          cur_sel, cur_sel_d;
    logic [TW-1:0] tmo, tmo_d;
    logic [HW-1:0] hold, hold_d;
    logic [31:0]   data_q, data_d;
    logic          mem_req_d;
    logic [31:0]   mem_addr_d;
    logic [31:0]   mem_addr_out_d, mem_data_out_d;
    logic          upd_d, sweep_done_d;

    // Absolute byte address of word i in the selected window (mod 2^32).
    function automatic logic [31:0] word_addr(input logic s, input logic [IW-1:0] i);
        logic [31:0] off;
        off = 32'(i) << 2;
        return (s ? RAM_BASE : ROM_BASE) + off;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cur_sel    <= 1'b0;
            tmo        <= '0;
            hold       <= '0;
            data_q     <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            MEM_Addr   <= '0;
            MEM_Data   <= '0;
            upd        <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            cur_sel    <= cur_sel_d;
            tmo        <= tmo_d;
            hold       <= hold_d;
            data_q     <= data_d;
            mem_req    <= mem_req_d;
            mem_addr   <= mem_addr_d;
            MEM_Addr   <= mem_addr_out_d;
            MEM_Data   <= mem_data_out_d;
            upd        <= upd_d;
            sweep_done <= sweep_done_d;
        end
    end

    always_comb begin
        state_d        = state;
        idx_d          = idx;
        cur_sel_d      = cur_sel;
        tmo_d          = tmo;
        hold_d         = hold;
        data_d         = data_q;
        mem_req_d      = mem_req;
        mem_addr_d     = mem_addr;
        mem_addr_out_d = MEM_Addr;
        mem_data_out_d = MEM_Data;
        upd_d          = 1'b0;
        sweep_done_d   = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    cur_sel_d  = sel;
                    idx_d      = '0;
                    tmo_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = word_addr(sel, '0);
                    state_d    = ISSUE;
                end
            end

            // Request stays up regardless of en/sel until ack or timeout.
            ISSUE: begin
                if (mem_ack) begin
                    data_d    = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = PRESENT;
                end else if (tmo == TMO_LAST) begin
                    data_d    = DEAD_DATA;
                    mem_req_d = 1'b0;
                    state_d   = PRESENT;
                end else if (tmo != TMO_MAX) begin
                    tmo_d = tmo + 1'b1;
                end
            end

            // Relative address uses the idx of the in-flight word, even if
            // sel has moved since the request went out.
            PRESENT: begin
                mem_addr_out_d = 32'(idx) << 2;
                mem_data_out_d = data_q;
                upd_d          = 1'b1;
                hold_d         = HW'(1);
                state_d        = HOLD;
            end

            HOLD: begin
                if (hold == HOLD_LAST) begin
                    tmo_d = '0;
                    if (!en) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        if (sel != cur_sel) begin
                            cur_sel_d = sel;
                            idx_d     = '0;
                        end else if (idx == IDX_LAST) begin
                            sweep_done_d = 1'b1;
                            idx_d        = '0;
                        end else begin
                            idx_d = idx + 1'b1;
                        end
                        mem_req_d  = 1'b1;
                        mem_addr_d = word_addr(cur_sel_d, idx_d);
                        state_d    = ISSUE;
                    end
                end else begin
                    hold_d = hold + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_scan_feeder.sv
// Directed bench for mem_scan_feeder (WORDS=4, ROM 0x100, RAM 0x1000,
// TIMEOUT=16, HOLD_CYC=2). A responder acks reads ack_dly cycles after the
// request rises with rdata = addr ^ 0xFFFF; a negedge monitor logs every
// presented pair, request and sweep_done pulse into queues that the
// scenarios then compare against hand-computed expectations.
module tb_mem_scan_feeder;

    localparam int          WORDS    = 4;
    localparam logic [31:0] ROM_BASE = 32'h100;
    localparam logic [31:0] RAM_BASE = 32'h1000;
    localparam int          TIMEOUT  = 16;
    localparam int          HOLD_CYC = 2;

    logic        clk = 1'b0;
    logic        rst, en, sel;
    logic        mem_req, mem_ack;
    logic [31:0] mem_addr, mem_rdata;
    logic [31:0] MEM_Addr, MEM_Data;
    logic        upd, sweep_done;

    mem_scan_feeder #(
        .WORDS(WORDS), .ROM_BASE(ROM_BASE), .RAM_BASE(RAM_BASE),
        .TIMEOUT(TIMEOUT), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sel(sel),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .MEM_Addr(MEM_Addr), .MEM_Data(MEM_Data),
        .upd(upd), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int          ack_dly     = 2;
    logic [31:0] no_ack_addr = 32'hFFFF_FFFF;
    bit          late_ack    = 1'b0;

    int          upd_cyc[$];
    logic [31:0] upd_a[$];
    logic [31:0] upd_d[$];
    logic [31:0] rq_addr[$];
    int          rq_cyc[$];
    int          rq_len[$];
    int          done_cyc[$];
    int          done_nupd[$];
    int          cur_len = 0;
    bit          prev_req = 1'b0;

    typedef struct {
        logic [31:0] req_addr;
        logic [31:0] maddr;
        logic [31:0] mdata;
    } vec_t;
    vec_t basic[5];

    // Responder: reacts #1 after each rising edge.
    initial begin
        int cnt;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (mem_req) begin
                if (cnt == ack_dly && mem_addr != no_ack_addr) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr ^ 32'hFFFF;
                end else begin
                    mem_ack = 1'b0;
                end
                cnt++;
            end else begin
                mem_ack   = late_ack;
                mem_rdata = late_ack ? 32'h1234_5678 : 32'h0;
                cnt       = 0;
            end
        end
    end

    // Monitor on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (upd) begin
                upd_cyc.push_back(cyc);
                upd_a.push_back(MEM_Addr);
                upd_d.push_back(MEM_Data);
            end
            if (mem_req && !prev_req) begin
                rq_addr.push_back(mem_addr);
                rq_cyc.push_back(cyc);
                cur_len = 0;
            end
            if (mem_req) cur_len++;
            if (!mem_req && prev_req) rq_len.push_back(cur_len);
            if (sweep_done) begin
                done_cyc.push_back(cyc);
                done_nupd.push_back(upd_a.size());
            end
            prev_req = mem_req;
        end else begin
            prev_req = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int w);
        case (w)
            0:       return upd_a.size();
            1:       return rq_addr.size();
            default: return rq_len.size();
        endcase
    endfunction

    // Bounded wait for queue 'w' to reach n entries; expiry counts as a failure.
    task automatic wait_q(input int w, input int n, input int budget, input string name);
        for (int k = 0; k < budget; k++) begin
            if (qsize(w) >= n) break;
            @(negedge clk);
            #1;
        end
        chk(name, 32'(qsize(w) >= n), 32'd1);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        en          = 1'b0;
        sel         = 1'b0;
        late_ack    = 1'b0;
        no_ack_addr = 32'hFFFF_FFFF;
        ack_dly     = 2;
        repeat (2) @(negedge clk);
        #1;
        upd_cyc.delete(); upd_a.delete(); upd_d.delete();
        rq_addr.delete(); rq_cyc.delete(); rq_len.delete();
        done_cyc.delete(); done_nupd.delete();
        rst = 1'b0;
    endtask

    initial begin
        basic[0] = '{32'h100, 32'h0, 32'hFEFF};
        basic[1] = '{32'h104, 32'h4, 32'hFEFB};
        basic[2] = '{32'h108, 32'h8, 32'hFEF7};
        basic[3] = '{32'h10C, 32'hC, 32'hFEF3};
        basic[4] = '{32'h100, 32'h0, 32'hFEFF};

        rst = 1'b0; en = 1'b0; sel = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_mem_req",    32'(mem_req),    32'h0);
        chk("rst_mem_addr",   mem_addr,        32'h0);
        chk("rst_MEM_Addr",   MEM_Addr,        32'h0);
        chk("rst_MEM_Data",   MEM_Data,        32'h0);
        chk("rst_upd",        32'(upd),        32'h0);
        chk("rst_sweep_done", 32'(sweep_done), 32'h0);

        // Basic sweep with wrap
        do_reset();
        en = 1'b1;
        wait_q(0, 5, 120, "basic_wait_upd");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("basic_req_addr[%0d]", i), rq_addr[i], basic[i].req_addr);
            chk($sformatf("basic_MEM_Addr[%0d]", i), upd_a[i],   basic[i].maddr);
            chk($sformatf("basic_MEM_Data[%0d]", i), upd_d[i],   basic[i].mdata);
            if (i > 0)
                chk($sformatf("basic_spacing[%0d]", i), 32'(upd_cyc[i] - upd_cyc[i-1]), 32'd6);
        end
        chk("basic_done_count", 32'(done_cyc.size()), 32'd1);
        chk("basic_done_after", 32'(done_nupd[0]),    32'd4);
        chk("basic_done_cycle", 32'(done_cyc[0]),     32'(rq_cyc[4]));

        // Asynchronous reset in the middle of ISSUE
        wait_q(1, 6, 60, "midrst_wait_req");
        chk("midrst_pre_req",  32'(mem_req), 32'h1);
        chk("midrst_pre_data", MEM_Data,     32'hFEFF);
        #2 rst = 1'b1;
        #1;
        chk("midrst_mem_req",    32'(mem_req),    32'h0);
        chk("midrst_mem_addr",   mem_addr,        32'h0);
        chk("midrst_MEM_Addr",   MEM_Addr,        32'h0);
        chk("midrst_MEM_Data",   MEM_Data,        32'h0);
        chk("midrst_upd",        32'(upd),        32'h0);
        chk("midrst_sweep_done", 32'(sweep_done), 32'h0);

        // Timeout at idx 1, late ack ignored
        do_reset();
        ack_dly     = 0;
        no_ack_addr = 32'h104;
        late_ack    = 1'b1;
        en          = 1'b1;
        wait_q(0, 3, 150, "tmo_wait_upd");
        chk("tmo_upd0_data", upd_d[0],          32'hFEFF);
        chk("tmo_req_len",   32'(rq_len[1]),    32'd16);
        chk("tmo_MEM_Addr",  upd_a[1],          32'h4);
        chk("tmo_MEM_Data",  upd_d[1],          32'hDEAD_BEEF);
        chk("tmo_next_req",  rq_addr[2],        32'h108);
        chk("tmo_next_addr", upd_a[2],          32'h8);
        chk("tmo_next_data", upd_d[2],          32'hFEF7);

        // sel toggle while idx 2 is in ISSUE
        do_reset();
        en = 1'b1;
        wait_q(1, 3, 100, "sel_wait_req");
        sel = 1'b1;
        wait_q(0, 4, 100, "sel_wait_upd");
        chk("sel_old_addr",   upd_a[2],                32'h8);
        chk("sel_old_data",   upd_d[2],                32'hFEF7);
        chk("sel_new_req",    rq_addr[3],              32'h1000);
        chk("sel_new_addr",   upd_a[3],                32'h0);
        chk("sel_new_data",   upd_d[3],                32'hEFFF);
        chk("sel_no_done",    32'(done_cyc.size()),    32'd0);

        // en dropped during ISSUE at idx 1
        do_reset();
        en = 1'b1;
        wait_q(1, 2, 100, "en_wait_req");
        en = 1'b0;
        wait_q(0, 2, 100, "en_wait_upd");
        repeat (20) @(negedge clk);
        #1;
        chk("en_req_len",    32'(rq_len[1]),       32'd3);
        chk("en_upd_addr",   upd_a[1],             32'h4);
        chk("en_no_new_req", 32'(rq_addr.size()),  32'd2);
        chk("en_idle_req",   32'(mem_req),         32'h0);
        chk("en_held_addr",  MEM_Addr,             32'h4);
        chk("en_held_data",  MEM_Data,             32'hFEFB);
        en = 1'b1;
        wait_q(1, 3, 50, "en_wait_restart");
        chk("en_restart_req", rq_addr[2], 32'h100);
        wait_q(0, 3, 50, "en_wait_restart_upd");
        chk("en_restart_addr", upd_a[2], 32'h0);
        chk("en_restart_data", upd_d[2], 32'hFEFF);

        // Back-to-back first-cycle acks
        do_reset();
        ack_dly = 0;
        en      = 1'b1;
        wait_q(0, 9, 200, "b2b_wait_upd");
        chk("b2b_req_len", 32'(rq_len[0]), 32'd1);
        for (int i = 1; i < 9; i++) begin
            chk($sformatf("b2b_spacing[%0d]", i), 32'(upd_cyc[i] - upd_cyc[i-1]), 32'd4);
            chk($sformatf("b2b_addr[%0d]", i), upd_a[i], 32'((i % 4) * 4));
            chk($sformatf("b2b_data[%0d]", i), upd_d[i], (ROM_BASE + 32'((i % 4) * 4)) ^ 32'hFFFF);
        end
        chk("b2b_done_count", 32'(done_cyc.size()), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
